// File: rtl/bp_pkg.sv
// Shared encodings for the (2,2) predictor core command port and the access scheduler FSM.
package bp_pkg;

  localparam logic [1:0] MODE_PREDICT = 2'b00;
  localparam logic [1:0] MODE_BRANCH  = 2'b01;
  localparam logic [1:0] MODE_DISPLAY = 2'b10;
  localparam logic [1:0] MODE_RESET   = 2'b11;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/bp_outcome_fifo.sv
// Small outcome FIFO (DEPTH x 1 bit) with flush; head is visible combinationally for BRANCH.
module bp_outcome_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  input  logic flush,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the current count, so a same-cycle pop never makes room for a push.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/bp_access_sched.sv
// Shares the predictor core command port between fetch (PREDICT) and resolve (BRANCH),
// buffering outcomes and sequencing table clears and dumps.
module bp_access_sched
  import bp_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pred_req,
  output logic       pred_gnt,
  output logic       pred_vld,
  output logic       pred_bit,
  input  logic       upd_vld,
  output logic       upd_rdy,
  input  logic       upd_taken,
  input  logic       clr_req,
  output logic       clr_busy,
  input  logic       dump_req,
  output logic [1:0] core_mode,
  output logic       core_cmd_v,
  output logic       core_inp,
  input  logic       core_pred
);

  localparam int DW = $clog2(MAX_DEFER + 1);

  state_t        state_reg, state_next;
  logic          clr_pend_reg, clr_pend_next;
  logic          dump_pend_reg, dump_pend_next;
  logic [DW-1:0] defer_reg, defer_next;
  logic          pred_vld_reg;
  logic          pred_bit_reg;

  logic clr_act;
  logic dump_act;
  logic fifo_head, fifo_full, fifo_empty;
  logic fifo_pop, fifo_flush;
  logic defer_max;

  // A request in the current cycle counts as pending so it wins arbitration immediately.
  assign clr_act   = clr_pend_reg || (clr_req && state_reg != S_CLEAR);
  assign dump_act  = dump_pend_reg || dump_req;
  assign clr_busy  = (state_reg != S_RUN) || clr_act;
  assign upd_rdy   = !fifo_full && (state_reg != S_CLEAR) && !clr_act;
  assign defer_max = (defer_reg == DW'(MAX_DEFER));

  bp_outcome_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (upd_vld && upd_rdy),
    .din   (upd_taken),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_INIT;
      clr_pend_reg  <= 1'b0;
      dump_pend_reg <= 1'b0;
      defer_reg     <= '0;
      pred_vld_reg  <= 1'b0;
      pred_bit_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_pend_reg  <= clr_pend_next;
      dump_pend_reg <= dump_pend_next;
      defer_reg     <= defer_next;
      pred_vld_reg  <= pred_gnt;
      if (pred_gnt) pred_bit_reg <= core_pred;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_pend_next  = clr_pend_reg;
    dump_pend_next = dump_act;
    defer_next     = fifo_empty ? '0 : defer_reg;
    core_cmd_v     = 1'b0;
    core_mode      = MODE_PREDICT;
    core_inp       = 1'b0;
    pred_gnt       = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;

    case (state_reg)
      S_INIT: begin
        core_cmd_v    = 1'b1;
        core_mode     = MODE_RESET;
        clr_pend_next = clr_act;
        state_next    = S_RUN;
      end
      S_CLEAR: begin
        core_cmd_v    = 1'b1;
        core_mode     = MODE_RESET;
        fifo_flush    = 1'b1;
        defer_next    = '0;
        clr_pend_next = 1'b0;
        state_next    = S_RUN;
      end
      S_RUN: begin
        if (clr_act) begin
          clr_pend_next = 1'b0;
          state_next    = S_CLEAR;
        end else if (fifo_full || (!dump_act && (defer_max || !pred_req) && !fifo_empty)) begin
          // BRANCH: forced by a full FIFO, a saturated defer count, or simply no predict request.
          core_cmd_v = 1'b1;
          core_mode  = MODE_BRANCH;
          core_inp   = fifo_head;
          fifo_pop   = 1'b1;
          defer_next = '0;
        end else if (dump_act) begin
          core_cmd_v     = 1'b1;
          core_mode      = MODE_DISPLAY;
          dump_pend_next = 1'b0;
        end else if (pred_req) begin
          core_cmd_v = 1'b1;
          core_mode  = MODE_PREDICT;
          pred_gnt   = 1'b1;
          if (!fifo_empty) defer_next = defer_max ? defer_reg : defer_reg + 1'b1;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  assign pred_vld = pred_vld_reg;
  assign pred_bit = pred_bit_reg;

endmodule

// File: tb/tb_bp_access_sched.sv
// Scoreboard bench: stimulus queues expected core commands and prediction bits; a monitor checks them.
module tb_bp_access_sched;
  import bp_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pred_req = 1'b0, upd_vld = 1'b0, upd_taken = 1'b0;
  logic       clr_req = 1'b0, dump_req = 1'b0, core_pred = 1'b0;
  logic       pred_gnt, pred_vld, pred_bit, upd_rdy, clr_busy, core_cmd_v, core_inp;
  logic [1:0] core_mode;

  int         checks = 0;
  int         failures = 0;
  logic [2:0] cmd_q[$];
  logic       pred_q[$];

  always #5 clk = ~clk;

  bp_access_sched #(.DEPTH(4), .MAX_DEFER(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .pred_req   (pred_req),
    .pred_gnt   (pred_gnt),
    .pred_vld   (pred_vld),
    .pred_bit   (pred_bit),
    .upd_vld    (upd_vld),
    .upd_rdy    (upd_rdy),
    .upd_taken  (upd_taken),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .dump_req   (dump_req),
    .core_mode  (core_mode),
    .core_cmd_v (core_cmd_v),
    .core_inp   (core_inp),
    .core_pred  (core_pred)
  );

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expc(input logic [1:0] mode, input logic inp);
    cmd_q.push_back({mode, inp});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (cmd_q.size() != 0 || pred_q.size() != 0); i++) tick();
    checks++;
    if (cmd_q.size() != 0 || pred_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d cmds %0d preds outstanding required 0 0",
               name, cmd_q.size(), pred_q.size());
    end
  endtask

  // Monitor: compare every issued command and every valid prediction against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_is_predict", {2'b00, pred_gnt}, {2'b00, core_cmd_v && core_mode == MODE_PREDICT});
      if (core_cmd_v) begin
        if (cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got mode=%0d inp=%0d required no command", core_mode, core_inp);
        end else begin
          $display("cmd mode=%0d inp=%0d", core_mode, core_inp);
          chk("cmd", {core_mode, core_inp}, cmd_q.pop_front());
        end
      end else begin
        chk("idle_clean", {core_mode, core_inp}, 3'b000);
      end
      if (pred_vld) begin
        if (pred_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pred: got pred_vld=1 bit=%0d required none", pred_bit);
        end else begin
          $display("pred bit=%0d", pred_bit);
          chk("pred_bit", {2'b00, pred_bit}, {2'b00, pred_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and first two cycles after release.
    tick(); tick();
    chk("rst_mode", {1'b0, core_mode}, 3'd3);
    chk("rst_cmdv", {2'b00, core_cmd_v}, 3'd1);
    chk("rst_busy", {2'b00, clr_busy}, 3'd1);
    chk("rst_rdy", {2'b00, upd_rdy}, 3'd1);
    chk("rst_pvld", {2'b00, pred_vld}, 3'd0);
    chk("rst_gnt", {2'b00, pred_gnt}, 3'd0);
    expc(MODE_RESET, 1'b0);
    rst = 1'b0;
    tick();
    chk("run_cmdv", {2'b00, core_cmd_v}, 3'd0);
    chk("run_busy", {2'b00, clr_busy}, 3'd0);
    chk("run_rdy", {2'b00, upd_rdy}, 3'd1);

    // Held pred_req: one grant per cycle, bits follow core_pred a cycle later.
    repeat (4) expc(MODE_PREDICT, 1'b0);
    pred_q.push_back(1'b1); pred_q.push_back(1'b1); pred_q.push_back(1'b1); pred_q.push_back(1'b0);
    pred_req = 1'b1; core_pred = 1'b1;
    tick(); tick(); tick();
    core_pred = 1'b0;
    tick();
    pred_req = 1'b0;
    drain("pred_held");

    // Defer limit: one outcome waits behind three non-empty PREDICT grants.
    repeat (4) expc(MODE_PREDICT, 1'b0);
    expc(MODE_BRANCH, 1'b1);
    expc(MODE_PREDICT, 1'b0);
    repeat (5) pred_q.push_back(1'b0);
    pred_req = 1'b1; core_pred = 1'b0; upd_vld = 1'b1; upd_taken = 1'b1;
    tick();
    upd_vld = 1'b0;
    repeat (5) tick();
    pred_req = 1'b0;
    drain("defer");

    // FIFO order with simultaneous push/pop, no predict traffic.
    expc(MODE_BRANCH, 1'b1); expc(MODE_BRANCH, 1'b1); expc(MODE_BRANCH, 1'b0); expc(MODE_BRANCH, 1'b1);
    upd_vld = 1'b1;
    upd_taken = 1'b1; tick();
    upd_taken = 1'b1; tick();
    upd_taken = 1'b0; tick();
    upd_taken = 1'b1; tick();
    upd_vld = 1'b0;
    drain("order");

    // Full FIFO forces BRANCH over pred_req while defer is still below the limit.
    expc(MODE_PREDICT, 1'b0); expc(MODE_DISPLAY, 1'b0); expc(MODE_PREDICT, 1'b0); expc(MODE_PREDICT, 1'b0);
    expc(MODE_BRANCH, 1'b1); expc(MODE_BRANCH, 1'b0); expc(MODE_BRANCH, 1'b1); expc(MODE_BRANCH, 1'b1);
    repeat (3) pred_q.push_back(1'b1);
    pred_req = 1'b1; core_pred = 1'b1; upd_vld = 1'b1;
    upd_taken = 1'b1; tick();
    upd_taken = 1'b0; dump_req = 1'b1; tick();
    dump_req = 1'b0; upd_taken = 1'b1; tick();
    upd_taken = 1'b1; tick();
    upd_taken = 1'b0;
    #1;
    chk("full_rdy", {2'b00, upd_rdy}, 3'd0);
    chk("full_gnt", {2'b00, pred_gnt}, 3'd0);
    tick();
    upd_vld = 1'b0; pred_req = 1'b0;
    drain("full");

    // Clear with simultaneous dump: no command, RESET, then DISPLAY; FIFO contents discarded.
    repeat (3) expc(MODE_PREDICT, 1'b0);
    expc(MODE_RESET, 1'b0);
    expc(MODE_DISPLAY, 1'b0);
    repeat (3) pred_q.push_back(1'b0);
    pred_req = 1'b1; core_pred = 1'b0; upd_vld = 1'b1; upd_taken = 1'b1;
    tick(); tick(); tick();
    pred_req = 1'b0; clr_req = 1'b1; dump_req = 1'b1;
    #1;
    chk("clr_busy_req", {2'b00, clr_busy}, 3'd1);
    chk("clr_rdy_req", {2'b00, upd_rdy}, 3'd0);
    chk("clr_cmdv_req", {2'b00, core_cmd_v}, 3'd0);
    tick();
    clr_req = 1'b0; dump_req = 1'b0; upd_vld = 1'b0;
    chk("clr_busy_clear", {2'b00, clr_busy}, 3'd1);
    tick(); tick();
    chk("clr_busy_done", {2'b00, clr_busy}, 3'd0);
    drain("clear");
    repeat (4) tick();

    // Reset mid-burst with two outcomes buffered.
    expc(MODE_PREDICT, 1'b0); expc(MODE_PREDICT, 1'b0);
    pred_q.push_back(1'b1);
    pred_req = 1'b1; core_pred = 1'b1; upd_vld = 1'b1; upd_taken = 1'b1;
    tick(); tick();
    upd_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_mode", {1'b0, core_mode}, 3'd3);
    chk("mid_rst_cmdv", {2'b00, core_cmd_v}, 3'd1);
    chk("mid_rst_pvld", {2'b00, pred_vld}, 3'd0);
    chk("mid_rst_pbit", {2'b00, pred_bit}, 3'd0);
    chk("mid_rst_gnt", {2'b00, pred_gnt}, 3'd0);
    chk("mid_rst_rdy", {2'b00, upd_rdy}, 3'd1);
    chk("mid_rst_busy", {2'b00, clr_busy}, 3'd1);
    pred_req = 1'b0;
    tick();
    expc(MODE_RESET, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmdv", {2'b00, core_cmd_v}, 3'd0);
    repeat (5) tick();
    drain("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
